// File: rtl/adc_snapshot.sv
// ADC capture stage: registers and converts both channels, runs the trigger FSM and
// stores a DEPTH-sample pre/post-trigger window in a circular buffer with a registered read port.
module adc_snapshot #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          adc_clk,
  input  logic          rst,
  input  logic [13:0]   adc_dat_a_i,
  input  logic [13:0]   adc_dat_b_i,
  input  logic          arm,
  input  logic [1:0]    trig_src,
  input  logic [13:0]   trig_level,
  input  logic [AW-1:0] pre_len,
  input  logic          trig_sw,
  input  logic          trig_ext_i,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] start_addr,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [13:0]        raw_a, raw_b;
  logic signed [15:0] cur_a, cur_b, prev_a;
  logic [2:0]         ext_sync;
  logic               ext_edge;
  logic [1:0]         src_q;
  logic signed [15:0] level_q;
  logic [AW-1:0]      pre_q, wr_ptr, fill_cnt, post_cnt;
  logic               prev_valid;
  logic               trig_hit, accept, we;
  logic [31:0]        mem [DEPTH];

  // Offset-binary to two's complement: keep the MSB, invert the rest, sign-extend.
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      raw_a    <= '0;
      raw_b    <= '0;
      cur_a    <= '0;
      cur_b    <= '0;
      prev_a   <= '0;
      ext_sync <= '0;
    end else begin
      raw_a    <= adc_dat_a_i;
      raw_b    <= adc_dat_b_i;
      cur_a    <= {{2{raw_a[13]}}, raw_a[13], ~raw_a[12:0]};
      cur_b    <= {{2{raw_b[13]}}, raw_b[13], ~raw_b[12:0]};
      prev_a   <= cur_a;
      ext_sync <= {ext_sync[1:0], trig_ext_i};
    end
  end

  assign ext_edge = ext_sync[1] & ~ext_sync[2];

  always_comb begin
    trig_hit = 1'b0;
    case (src_q)
      2'd0:    trig_hit = trig_sw;
      2'd1:    trig_hit = prev_valid && (prev_a < level_q) && (cur_a >= level_q);
      2'd2:    trig_hit = prev_valid && (prev_a > level_q) && (cur_a <= level_q);
      default: trig_hit = ext_edge;
    endcase
  end

  assign we     = ((state == ARMED) || (state == POST)) && !arm && !rst;
  assign accept = (state == ARMED) && !arm && (fill_cnt == pre_q) && trig_hit;
  assign busy   = (state == ARMED) || (state == POST);
  assign done   = (state == DONE);

  always_ff @(posedge adc_clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      post_cnt   <= '0;
      start_addr <= '0;
      src_q      <= '0;
      level_q    <= '0;
      pre_q      <= '0;
      prev_valid <= 1'b0;
    end else if (arm) begin
      state      <= ARMED;
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      post_cnt   <= '0;
      prev_valid <= 1'b0;
      src_q      <= trig_src;
      level_q    <= {{2{trig_level[13]}}, trig_level};
      pre_q      <= pre_len;
    end else begin
      case (state)
        ARMED: begin
          wr_ptr     <= wr_ptr + AW'(1);
          prev_valid <= 1'b1;
          if (fill_cnt != pre_q) fill_cnt <= fill_cnt + AW'(1);
          if (accept) begin
            start_addr <= wr_ptr - pre_q;
            // DEPTH-1 is all ones in AW bits, so post_cnt = DEPTH - pre_len - 1
            post_cnt   <= '1 - pre_q;
            state      <= (pre_q == '1) ? DONE : POST;
          end
        end
        POST: begin
          wr_ptr   <= wr_ptr + AW'(1);
          post_cnt <= post_cnt - AW'(1);
          if (post_cnt == AW'(1)) state <= DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge adc_clk) begin
    if (we) mem[wr_ptr] <= {cur_b, cur_a};
  end

  always_ff @(posedge adc_clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_adc_snapshot.sv
// Directed bench for adc_snapshot (DEPTH=16): capture, conversion, level/external triggers,
// pre-trigger gating with pointer wrap, restart and reset during POST.
module tb_adc_snapshot;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          adc_clk = 1'b0;
  logic          rst = 1'b1;
  logic [13:0]   adc_dat_a_i = '0;
  logic [13:0]   adc_dat_b_i = '0;
  logic          arm = 1'b0;
  logic [1:0]    trig_src = '0;
  logic [13:0]   trig_level = '0;
  logic [AW-1:0] pre_len = '0;
  logic          trig_sw = 1'b0;
  logic          trig_ext_i = 1'b0;
  logic          busy, done;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] rd_addr = '0;
  logic [31:0]   rd_data;

  int          n_checks = 0;
  int          n_err = 0;
  logic        ramp_on = 1'b0;
  int          s_a = 0;
  int          ramp_step = 1;
  int          trig_s;
  int          n;
  logic [31:0] d;

  adc_snapshot #(.DEPTH(DEPTH), .AW(AW)) dut (
    .adc_clk(adc_clk), .rst(rst), .adc_dat_a_i(adc_dat_a_i), .adc_dat_b_i(adc_dat_b_i),
    .arm(arm), .trig_src(trig_src), .trig_level(trig_level), .pre_len(pre_len),
    .trig_sw(trig_sw), .trig_ext_i(trig_ext_i), .busy(busy), .done(done),
    .start_addr(start_addr), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 adc_clk = ~adc_clk;

  // Raw pin code that converts to the given signed sample value
  function automatic logic [13:0] to_raw(input int s);
    logic [15:0] v;
    v = 16'(s);
    return {v[13], ~v[12:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge adc_clk);
    #1;
    if (ramp_on) begin
      s_a += ramp_step;
      adc_dat_a_i = to_raw(s_a);
    end
  endtask

  task automatic set_a(input int s);
    s_a = s;
    adc_dat_a_i = to_raw(s);
  endtask

  task automatic read(input int a, output logic [31:0] q);
    rd_addr = AW'(a);
    tick;
    q = rd_data;
  endtask

  task automatic wait_done(input int limit, output int cnt);
    cnt = 0;
    while (!done && cnt < limit) begin
      tick;
      cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=still running expected=finished");
    $fatal(1);
  end

  initial begin
    // Reset state
    adc_dat_b_i = 14'h1234;
    set_a(-1);
    tick; tick;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_start", 32'(start_addr), 32'd0);
    chk("rst_rd", rd_data, 32'd0);
    rst = 1'b0;
    tick;

    // 1: software trigger, pre_len=0, descending converted ramp (raw 0x2000+n)
    ramp_step = -1; ramp_on = 1'b1;
    trig_src = 2'd0; pre_len = '0; arm = 1'b1;
    tick; arm = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    repeat (4) tick;
    trig_sw = 1'b1; trig_s = s_a + 2;
    tick; trig_sw = 1'b0;
    chk("t1_start", 32'(start_addr), 32'd4);
    wait_done(40, n);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_post_cycles", 32'(n), 32'd15);
    chk("t1_busy_done", 32'(busy), 32'd0);
    for (int k = 0; k < 16; k++) begin
      read(4 + k, d);
      chk("t1_rd", d, {16'h0DCB, 16'(trig_s - k)});
    end
    ramp_on = 1'b0;

    // 2: conversion of 0x0000, 0x3FFF, 0x2000
    adc_dat_a_i = 14'h0000;
    tick; tick;
    arm = 1'b1;
    tick; arm = 1'b0; trig_sw = 1'b1;
    tick; trig_sw = 1'b0; adc_dat_a_i = 14'h3FFF;
    chk("t2_start", 32'(start_addr), 32'd0);
    repeat (5) tick;
    adc_dat_a_i = 14'h2000;
    wait_done(40, n);
    chk("t2_done", 32'(done), 32'd1);
    read(0, d);  chk("t2_conv_0000_a", 32'(d[15:0]), 32'h1FFF);
    read(2, d);  chk("t2_conv_0000_b", 32'(d[15:0]), 32'h1FFF);
    read(3, d);  chk("t2_conv_3fff_a", 32'(d[15:0]), 32'hE000);
    read(7, d);  chk("t2_conv_3fff_b", 32'(d[15:0]), 32'hE000);
    read(8, d);  chk("t2_conv_2000_a", 32'(d[15:0]), 32'hFFFF);
    read(15, d); chk("t2_conv_2000_b", 32'(d[15:0]), 32'hFFFF);

    // 3: rising level trigger at 100, pre_len=4, ramp -50 step +10
    ramp_step = 10; set_a(-50); ramp_on = 1'b1;
    tick;
    trig_src = 2'd1; trig_level = 14'd100; pre_len = AW'(4); arm = 1'b1;
    tick; arm = 1'b0;
    chk("t3_busy", 32'(busy), 32'd1);
    wait_done(60, n);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_start", 32'(start_addr), 32'd11);
    read(15, d); chk("t3_trig_sample", 32'(d[15:0]), 32'(16'd100));
    read(14, d); chk("t3_pre_last", 32'(d[15:0]), 32'(16'd90));
    read(11, d); chk("t3_oldest", 32'(d[15:0]), 32'(16'd60));
    read(0, d);  chk("t3_post_first", 32'(d[15:0]), 32'(16'd110));
    ramp_on = 1'b0;

    // 4: early trigger ignored, late trigger with start_addr wrap
    ramp_step = 1; set_a(0); ramp_on = 1'b1;
    trig_src = 2'd0; pre_len = AW'(8); arm = 1'b1;
    tick; arm = 1'b0;
    tick; tick;
    trig_sw = 1'b1;
    tick; trig_sw = 1'b0;
    chk("t4_early_busy", 32'(busy), 32'd1);
    chk("t4_early_done", 32'(done), 32'd0);
    chk("t4_early_start", 32'(start_addr), 32'd11);
    repeat (15) tick;
    trig_sw = 1'b1; trig_s = s_a - 2;
    tick; trig_sw = 1'b0;
    chk("t4_start_wrap", 32'(start_addr), 32'd10);
    wait_done(40, n);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_post_cycles", 32'(n), 32'd7);
    read(2, d);  chk("t4_trig_sample", 32'(d[15:0]), 32'(16'(trig_s)));
    read(10, d); chk("t4_oldest", 32'(d[15:0]), 32'(16'(trig_s - 8)));
    read(9, d);  chk("t4_newest", 32'(d[15:0]), 32'(16'(trig_s + 7)));
    ramp_on = 1'b0;

    // 5: external trigger, 3-cycle recognition, held level does not re-trigger
    trig_src = 2'd3; pre_len = '0; trig_ext_i = 1'b0; arm = 1'b1;
    tick; arm = 1'b0;
    repeat (3) tick;
    #2 trig_ext_i = 1'b1;
    tick; tick;
    chk("t5_not_yet", 32'(start_addr), 32'd10);
    tick;
    chk("t5_start", 32'(start_addr), 32'd5);
    wait_done(40, n);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_post_cycles", 32'(n), 32'd15);
    arm = 1'b1;
    tick; arm = 1'b0;
    repeat (20) tick;
    chk("t5_held_busy", 32'(busy), 32'd1);
    chk("t5_held_done", 32'(done), 32'd0);
    chk("t5_held_start", 32'(start_addr), 32'd5);

    // 6: arm during POST restarts; rst during POST stops writes
    trig_ext_i = 1'b0; trig_src = 2'd0; pre_len = '0; arm = 1'b1;
    tick; arm = 1'b0; trig_sw = 1'b1;
    tick; trig_sw = 1'b0;
    chk("t6_start0", 32'(start_addr), 32'd0);
    chk("t6_post_busy", 32'(busy), 32'd1);
    set_a(341);
    repeat (3) tick;
    arm = 1'b1;
    tick; arm = 1'b0;
    chk("t6_restart_busy", 32'(busy), 32'd1);
    chk("t6_restart_done", 32'(done), 32'd0);
    repeat (20) tick;
    chk("t6_no_done", 32'(done), 32'd0);
    chk("t6_start_kept", 32'(start_addr), 32'd0);
    set_a(-77);
    tick; tick;
    trig_sw = 1'b1;
    tick; trig_sw = 1'b0;
    chk("t6_start", 32'(start_addr), 32'd6);
    tick;
    rst = 1'b1;
    tick;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_rd", rd_data, 32'd0);
    rst = 1'b0;
    set_a(1000);
    repeat (20) tick;
    read(5, d); chk("t6_before", 32'(d[15:0]), 32'h0155);
    read(6, d); chk("t6_trig", 32'(d[15:0]), 32'hFFB3);
    read(7, d); chk("t6_last", 32'(d[15:0]), 32'hFFB3);
    read(8, d); chk("t6_no_write", 32'(d[15:0]), 32'h0155);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
